// File: rtl/rom_rd_pkg.sv
// Shared types and constants for the ROM stream reader.
package rom_rd_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;
  // Words that can be owned at once: buffered entries plus the read in flight.
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rom_rd_skid_fifo.sv
// Two-entry FIFO holding {last, data} words returned by the ROM.
module rom_rd_skid_fifo
  import rom_rd_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   occ_q;

  // Storage, pointers and occupancy; the reader never pushes into a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst reader: issues ROM reads, absorbs the one-cycle read latency and
// streams the words out on valid/ready with full backpressure.
module rom_stream_reader
  import rom_rd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              done_q, done_d;
  logic              inflight_q, last_pipe_q;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        need, room;

  assign pop = m_valid && m_ready;

  // Issue only if the word we launch now still has a slot when it lands.
  assign need   = {1'b0, occ} + {2'b0, inflight_q} + 3'd1;
  assign room   = 3'(FIFO_DEPTH) + {2'b0, pop};
  assign rom_en = (state_q == ST_RUN) && (need <= room);

  // Next-state, address and word-count update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        addr_d  = start_addr;
        rem_d   = (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, length};
        state_d = ST_RUN;
      end
      ST_RUN: if (rom_en) begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (pop && m_last) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; the read pipeline flags follow rom_en by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
      last_pipe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      inflight_q  <= rom_en;
      last_pipe_q <= rom_en && (rem_q == (ADDR_W+1)'(1));
    end
  end

  rom_rd_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i ({last_pipe_q, rom_data}),
    .pop_i       (pop),
    .head_o      ({m_last, m_data}),
    .occ_o       (occ)
  );

  assign m_valid  = (occ != 2'd0);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign rom_addr = addr_q;

endmodule
